// File: rtl/decode_stage.sv
// RV32I decode stage: decodes fetched words into the ALU operation encoding and
// holds them in an output register backed by a one-entry skid buffer.

package decode_stage_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OPIMM  = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_t;

  typedef struct packed {
    logic [2:0] funct3;
    logic [6:0] funct7;
  } operation_t;

endpackage

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output opcode_t         out_opcode,
  output operation_t      out_op,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_a_is_pc,
  output logic            out_use_rs2,
  output logic            out_writes_rd,
  output logic            out_illegal
);

  typedef struct packed {
    opcode_t         opcode;
    operation_t      op;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            a_is_pc;
    logic            use_rs2;
    logic            writes_rd;
    logic            illegal;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  beat_t  dec;
  beat_t  out_q, skid_q;
  logic   load_out_in, load_out_skid, load_skid;
  logic   accept, drain;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       known, rd_class, bad_fields;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  // Decode happens ahead of storage so both OUT and SKID hold finished fields.
  always_comb begin
    dec            = '0;
    known          = 1'b1;
    rd_class       = 1'b0;
    bad_fields     = 1'b0;
    dec.opcode     = opcode_t'(opc);
    dec.instr      = in_instr;
    dec.pc         = in_pc;
    dec.rs1        = in_instr[19:15];
    dec.rs2        = in_instr[24:20];
    dec.rd         = in_instr[11:7];
    case (opc)
      OPC_LUI: rd_class = 1'b1;
      OPC_AUIPC: begin
        rd_class    = 1'b1;
        dec.a_is_pc = 1'b1;
      end
      OPC_JAL: begin
        rd_class    = 1'b1;
        dec.a_is_pc = 1'b1;
      end
      OPC_JALR: begin
        rd_class       = 1'b1;
        dec.op.funct3  = f3;
        bad_fields     = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.a_is_pc    = 1'b1;
        dec.use_rs2    = 1'b1;
        dec.op.funct3  = f3;
        bad_fields     = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        rd_class       = 1'b1;
        dec.op.funct3  = f3;
        bad_fields     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.use_rs2    = 1'b1;
        dec.op.funct3  = f3;
        bad_fields     = (f3 > 3'b010);
      end
      OPC_OPIMM: begin
        rd_class       = 1'b1;
        dec.op.funct3  = f3;
        // Only the shift forms carry funct7; elsewhere those bits are immediate.
        if (f3 == 3'b001) begin
          dec.op.funct7 = f7;
          bad_fields    = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          dec.op.funct7 = f7;
          bad_fields    = (f7 != 7'b0000000) && (f7 != 7'b0100000);
        end
      end
      OPC_OP: begin
        rd_class       = 1'b1;
        dec.use_rs2    = 1'b1;
        dec.op.funct3  = f3;
        dec.op.funct7  = f7;
        bad_fields     = ((f7 != 7'b0000000) && (f7 != 7'b0100000)) ||
                         ((f7 == 7'b0100000) && (f3 != 3'b000) && (f3 != 3'b101));
      end
      default: known = 1'b0;
    endcase
    dec.illegal   = bad_fields || !known || (in_instr[1:0] != 2'b11);
    dec.writes_rd = rd_class && (in_instr[11:7] != 5'd0) && !dec.illegal;
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            load_out_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_out_in = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d       = ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_in)        out_q <= dec;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= dec;
    end
  end

  assign out_opcode    = out_q.opcode;
  assign out_op        = out_q.op;
  assign out_instr     = out_q.instr;
  assign out_pc        = out_q.pc;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_rd        = out_q.rd;
  assign out_a_is_pc   = out_q.a_is_pc;
  assign out_use_rs2   = out_q.use_rs2;
  assign out_writes_rd = out_q.writes_rd;
  assign out_illegal   = out_q.illegal;

endmodule
